alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one 16-bit ALU datapath between two requesters.
- Each requester issues commands {opcode, A, B} over a valid/ready handshake.
- A round-robin FSM grants one command at a time, registers the operands into the ALU, captures the result and flags, and returns them on a single response channel tagged with the requester id.
- Sits between the issue logic and the shared ALU; it is the only driver of the ALU inputs.

Parameters:
- NUMBITS, 16: operand/result width.
- CNTBITS, 16: width of per-requester grant counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 command valid.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_opcode  input  3  requester 0 ALU opcode.
- req0_a  input  NUMBITS  requester 0 operand A.
- req0_b  input  NUMBITS  requester 0 operand B.
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester that issued the command.
- rsp_result  output  NUMBITS  ALU result.
- rsp_carryout  output  1  unsigned carry/borrow flag.
- rsp_overflow  output  1  signed overflow flag.
- rsp_zero  output  1  result == 0.
- busy  output  1  FSM not in IDLE.
- grant_count0, grant_count1  output  CNTBITS  saturating count of accepted commands per requester.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE; all rsp_* outputs are 0; busy is 0.
  - Both grant counters are 0; last_grant is 1, so requester 0 wins the first contention.
  - Any in-flight command is dropped and no response is issued for it.
- FSM states and transitions:
  - IDLE -> EXEC when a handshake occurs.
  - EXEC -> RESP unconditionally after 1 cycle.
  - RESP -> IDLE when rsp_ready is high.
- Grant rule (IDLE only):
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester not equal to last_grant is granted.
  - reqN_ready is combinational: 1 only for the granted requester, only in IDLE.
  - In EXEC and RESP, both readys are 0.
- Handshake:
  - Accept when reqN_valid && reqN_ready.
  - On that edge, register opcode/A/B and id, update last_grant, and increment grant_countN.
  - grant_countN saturates at all-ones and never wraps.
- Requester rule: a requester must hold valid and its payload stable until ready; a requester dropping valid before ready is not an error and no grant is recorded.
- EXEC:
  - The registered operands drive the ALU, which is combinational.
  - On the exit edge, result and flags are captured into the rsp_* registers and rsp_valid is set to 1.
- RESP:
  - rsp_* hold stable while rsp_valid && !rsp_ready.
  - On the rsp_ready edge, rsp_valid clears.
- Latency and throughput:
  - Accept at edge N gives rsp_valid high after edge N+1.
  - With rsp_ready tied high, the minimum issue interval is 3 cycles.
- ALU opcode semantics (NUMBITS-wide, wrap-around):
  - 000: unsigned add; carryout = carry out of the MSB.
  - 001: signed add; overflow = operands share a sign and the result sign differs.
  - 010: unsigned sub; carryout = borrow (A < B).
  - 011: signed sub; overflow = operands differ in sign and the result sign differs from A.
  - 100: AND. 101: OR. 110: XOR.
  - 111: logical shift right of A by 1.
  - Flags not defined for an opcode are 0; zero is valid for all opcodes.
- Simultaneous events:
  - Requests arriving during EXEC/RESP wait.
  - rsp_ready high in the same cycle rsp_valid rises is consumed on the next edge.
  - A new grant cannot occur in the same cycle as the RESP->IDLE transition.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADDU=3'b000 … OP_SRL=3'b111);
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - requester id width.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with a last_grant register.
- The ALU itself is instantiated as the existing team datapath, with its reset tied inactive.

Test Plan:
- Reset release, req0 {000, A=16'hFFFF, B=16'h0001}, rsp_ready=1 -> rsp_result=0, carryout=1, zero=1, rsp_id=0, grant_count0=1.
- req1 {001, A=16'h7FFF, B=16'h0001} -> result=16'h8000, overflow=1, carryout=0, zero=0, rsp_id=1.
- Both valid continuously with rsp_ready=1, 6 commands -> grants alternate 0,1,0,1,0,1; each grant_count=3; no ready asserted in EXEC/RESP.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid on {010, A=3, B=5} -> result=16'hFFFE and carryout=1 held stable, req readys stay 0; rsp_ready=1 -> IDLE next edge.
- Reset asserted during EXEC of {111, A=16'h8001} -> rsp_valid stays 0, counters 0, busy 0; after release, the first grant goes to req0 when both are valid.
- Preload grant_count0 to 16'hFFFF via 65535 accepts -> one more accept leaves it at 16'hFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encoding and flag helpers for the ALU arbiter
package alu_pkg;

  localparam int ID_W = 1;

  localparam logic [2:0] OP_ADDU = 3'b000;
  localparam logic [2:0] OP_ADDS = 3'b001;
  localparam logic [2:0] OP_SUBU = 3'b010;
  localparam logic [2:0] OP_SUBS = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_SRL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } alu_flags_t;

  // Two's-complement overflow from operand/result sign bits; subtraction flips the B-sign test.
  function automatic logic signed_ovf(input logic sign_a, input logic sign_b,
                                      input logic sign_r, input logic is_sub);
    if (is_sub) return (sign_a != sign_b) && (sign_r != sign_a);
    return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between issue logic and the ALU arbiter
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int NUMBITS = 16,
  parameter int CNTBITS = 16
);
  logic               req0_valid;
  logic               req0_ready;
  logic [2:0]         req0_opcode;
  logic [NUMBITS-1:0] req0_a;
  logic [NUMBITS-1:0] req0_b;

  logic               req1_valid;
  logic               req1_ready;
  logic [2:0]         req1_opcode;
  logic [NUMBITS-1:0] req1_a;
  logic [NUMBITS-1:0] req1_b;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [NUMBITS-1:0] rsp_result;
  logic               rsp_carryout;
  logic               rsp_overflow;
  logic               rsp_zero;

  logic               busy;
  logic [CNTBITS-1:0] grant_count0;
  logic [CNTBITS-1:0] grant_count1;

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_zero,
    input  busy, grant_count0, grant_count1
  );

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_zero,
    output busy, grant_count0, grant_count1
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - shared ALU datapath: operand registers feeding a combinational ALU
module alu_datapath
  import alu_pkg::*;
#(
  parameter int NUMBITS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [2:0]         opcode_i,
  input  logic [NUMBITS-1:0] a_i,
  input  logic [NUMBITS-1:0] b_i,
  output logic [NUMBITS-1:0] result_o,
  output alu_flags_t         flags_o
);

  logic [2:0]         op_q;
  logic [NUMBITS-1:0] a_q;
  logic [NUMBITS-1:0] b_q;
  logic [NUMBITS:0]   sum_w;
  logic [NUMBITS:0]   diff_w;
  logic [NUMBITS-1:0] res_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_ADDU;
      a_q  <= '0;
      b_q  <= '0;
    end else if (load_i) begin
      op_q <= opcode_i;
      a_q  <= a_i;
      b_q  <= b_i;
    end
  end

  // The extra top bit of sum/diff is the unsigned carry or borrow.
  always_comb begin
    sum_w            = {1'b0, a_q} + {1'b0, b_q};
    diff_w           = {1'b0, a_q} - {1'b0, b_q};
    res_w            = '0;
    flags_o.carry    = 1'b0;
    flags_o.overflow = 1'b0;
    case (op_q)
      OP_ADDU: begin
        res_w         = sum_w[NUMBITS-1:0];
        flags_o.carry = sum_w[NUMBITS];
      end
      OP_ADDS: begin
        res_w            = sum_w[NUMBITS-1:0];
        flags_o.overflow = signed_ovf(a_q[NUMBITS-1], b_q[NUMBITS-1], sum_w[NUMBITS-1], 1'b0);
      end
      OP_SUBU: begin
        res_w         = diff_w[NUMBITS-1:0];
        flags_o.carry = diff_w[NUMBITS];
      end
      OP_SUBS: begin
        res_w            = diff_w[NUMBITS-1:0];
        flags_o.overflow = signed_ovf(a_q[NUMBITS-1], b_q[NUMBITS-1], diff_w[NUMBITS-1], 1'b1);
      end
      OP_AND:  res_w = a_q & b_q;
      OP_OR:   res_w = a_q | b_q;
      OP_XOR:  res_w = a_q ^ b_q;
      OP_SRL:  res_w = {1'b0, a_q[NUMBITS-1:1]};
      default: res_w = '0;
    endcase
    flags_o.zero = ~|res_w;
    result_o     = res_w;
  end

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - two-way round-robin grant with a last-winner register
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  logic last_q;
  logic last_d;

  // Grants only go to a valid requester, so any grant is also a handshake.
  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      unique case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (|grant_o) last_d = grant_o[1];
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters with a tagged response
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUMBITS = 16,
  parameter int CNTBITS = 16
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  arb_state_e         state_q;
  logic               busy_q;
  logic [ID_W-1:0]    id_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [NUMBITS-1:0] rsp_result_q;
  alu_flags_t         rsp_flags_q;
  logic [CNTBITS-1:0] cnt0_q;
  logic [CNTBITS-1:0] cnt1_q;

  logic [1:0]         valid_w;
  logic [1:0]         grant_w;
  logic               accept_w;
  logic [2:0]         op_sel_w;
  logic [NUMBITS-1:0] a_sel_w;
  logic [NUMBITS-1:0] b_sel_w;
  logic [NUMBITS-1:0] alu_result_w;
  alu_flags_t         alu_flags_w;

  assign valid_w = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (reset),
    .enable_i (state_q == IDLE),
    .valid_i  (valid_w),
    .grant_o  (grant_w)
  );

  assign bus.req0_ready = grant_w[0];
  assign bus.req1_ready = grant_w[1];
  assign accept_w       = |grant_w;

  assign op_sel_w = grant_w[1] ? bus.req1_opcode : bus.req0_opcode;
  assign a_sel_w  = grant_w[1] ? bus.req1_a      : bus.req0_a;
  assign b_sel_w  = grant_w[1] ? bus.req1_b      : bus.req0_b;

  // The ALU's own reset is held inactive; a dropped command simply leaves stale operands behind.
  alu_datapath #(.NUMBITS(NUMBITS)) u_alu (
    .clk      (clk),
    .rst_n    (1'b1),
    .load_i   (accept_w),
    .opcode_i (op_sel_w),
    .a_i      (a_sel_w),
    .b_i      (b_sel_w),
    .result_o (alu_result_w),
    .flags_o  (alu_flags_w)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_w) begin
            state_q <= EXEC;
            busy_q  <= 1'b1;
            id_q    <= grant_w[1];
            if (grant_w[0] && !(&cnt0_q)) cnt0_q <= cnt0_q + CNTBITS'(1);
            if (grant_w[1] && !(&cnt1_q)) cnt1_q <= cnt1_q + CNTBITS'(1);
          end
        end
        EXEC: begin
          state_q      <= RESP;
          rsp_valid_q  <= 1'b1;
          rsp_id_q     <= id_q;
          rsp_result_q <= alu_result_w;
          rsp_flags_q  <= alu_flags_w;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_carryout = rsp_flags_q.carry;
  assign bus.rsp_overflow = rsp_flags_q.overflow;
  assign bus.rsp_zero     = rsp_flags_q.zero;
  assign bus.busy         = busy_q;
  assign bus.grant_count0 = cnt0_q;
  assign bus.grant_count1 = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NB   = 16;
  localparam int CB   = 8;
  localparam int CMAX = (1 << CB) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUMBITS(NB), .CNTBITS(CB)) bus ();

  // Narrow grant counters keep the saturation run short.
  alu_arbiter #(.NUMBITS(NB), .CNTBITS(CB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          id;
    logic [NB-1:0] res;
    logic          c;
    logic          v;
    logic          z;
  } exp_t;

  typedef struct {
    logic          id;
    logic [2:0]    op;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    exp_t          e;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[12];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_cnt0 = 0;
  int   exp_cnt1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic id, input logic [2:0] op, input logic [NB-1:0] a,
                              input logic [NB-1:0] b, input logic [NB-1:0] res,
                              input logic c, input logic v, input logic z);
    vec_t t;
    t.id = id; t.op = op; t.a = a; t.b = b;
    t.e.id = id; t.e.res = res; t.e.c = c; t.e.v = v; t.e.z = z;
    return t;
  endfunction

  function automatic vec_t cmd_vec(input logic id, input int i);
    if (!id) return mk(1'b0, OP_ADDU, NB'(i * 3), 16'h0100, NB'(16'h0100 + i * 3), 1'b0, 1'b0, 1'b0);
    return mk(1'b1, OP_XOR, 16'hFF00, NB'(i), 16'hFF00 | NB'(i), 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic int bump(input int c);
    return (c < CMAX) ? c + 1 : c;
  endfunction

  // Scoreboard pop on every response handshake, plus a standing no-ready-while-busy check.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      if (bus.busy) check("ready_while_busy", {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_id", bus.rsp_id, e.id);
          check("rsp_result", bus.rsp_result, e.res);
          check("rsp_carryout", bus.rsp_carryout, e.c);
          check("rsp_overflow", bus.rsp_overflow, e.v);
          check("rsp_zero", bus.rsp_zero, e.z);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic v, input logic [2:0] op,
                       input logic [NB-1:0] a, input logic [NB-1:0] b);
    if (!id) begin
      bus.req0_valid = v; bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic send(input vec_t t, input bit push);
    int n;
    n = 0;
    if (push) sb_q.push_back(t.e);
    drive(t.id, 1'b1, t.op, t.a, t.b);
    #1;
    while (!(t.id ? bus.req1_ready : bus.req0_ready) && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 40) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    drive(t.id, 1'b0, t.op, t.a, t.b);
    if (!t.id) exp_cnt0 = bump(exp_cnt0);
    else       exp_cnt1 = bump(exp_cnt1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.rsp_valid) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Both requesters held valid; expected order assumes requester 0 wins first.
  task automatic run_both(input int per);
    int   i0, i1, n;
    logic a0, a1;
    vec_t t0, t1;
    i0 = 0; i1 = 0; n = 0;
    for (int k = 0; k < per; k++) begin
      t0 = cmd_vec(1'b0, k);
      t1 = cmd_vec(1'b1, k);
      sb_q.push_back(t0.e);
      sb_q.push_back(t1.e);
    end
    t0 = cmd_vec(1'b0, 0);
    t1 = cmd_vec(1'b1, 0);
    drive(1'b0, 1'b1, t0.op, t0.a, t0.b);
    drive(1'b1, 1'b1, t1.op, t1.a, t1.b);
    #1;
    check("first_grant", {30'b0, bus.req1_ready, bus.req0_ready}, 32'd1);
    while ((i0 < per || i1 < per) && n < 20 * per) begin
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      if (a0 && a1) check("both_ready", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      n++;
      if (a0) begin
        i0++;
        exp_cnt0 = bump(exp_cnt0);
        t0 = cmd_vec(1'b0, i0);
        drive(1'b0, (i0 < per), t0.op, t0.a, t0.b);
      end
      if (a1) begin
        i1++;
        exp_cnt1 = bump(exp_cnt1);
        t1 = cmd_vec(1'b1, i1);
        drive(1'b1, (i1 < per), t1.op, t1.a, t1.b);
      end
      #1;
    end
    if (i0 < per || i1 < per) check("run_both_timeout", 32'd0, 32'd1);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not reach summary, actual timeout required finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(1'b0, OP_ADDU, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    tbl[1]  = mk(1'b1, OP_ADDS, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, OP_SUBU, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, OP_SUBS, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, OP_OR,   16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, OP_XOR,  16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[7]  = mk(1'b1, OP_SRL,  16'h8001, 16'h1234, 16'h4000, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, OP_ADDU, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, OP_ADDS, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1);
    tbl[10] = mk(1'b0, OP_SUBU, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(1'b1, OP_SUBS, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b0);

    drive(1'b0, 1'b0, 3'b000, '0, '0);
    drive(1'b1, 1'b0, 3'b000, '0, '0);
    bus.rsp_ready = 1'b1;
    reset = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_rsp_id", bus.rsp_id, 32'd0);
    check("rst_count0", bus.grant_count0, 32'd0);
    check("rst_count1", bus.grant_count1, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      send(tbl[i], 1'b1);
      check("exec_no_rsp", bus.rsp_valid, 32'd0);
      check("exec_busy", bus.busy, 32'd1);
      tick();
      check("rsp_latency", bus.rsp_valid, 32'd1);
      tick();
      check("rsp_consumed", bus.rsp_valid, 32'd0);
      check("idle_not_busy", bus.busy, 32'd0);
      check("grant_count0", bus.grant_count0, exp_cnt0);
      check("grant_count1", bus.grant_count1, exp_cnt1);
    end

    reset = 1'b0;
    tick();
    check("rst2_count0", bus.grant_count0, 32'd0);
    reset = 1'b1;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    run_both(3);
    wait_idle();
    check("alt_count0", bus.grant_count0, 32'd3);
    check("alt_count1", bus.grant_count1, 32'd3);

    bus.rsp_ready = 1'b0;
    send(mk(1'b0, OP_SUBU, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0), 1'b1);
    drive(1'b1, 1'b1, OP_AND, 16'h0001, 16'h0001);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", bus.rsp_valid, 32'd1);
      check("bp_result", bus.rsp_result, 32'hFFFE);
      check("bp_carryout", bus.rsp_carryout, 32'd1);
      check("bp_readys", {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    drive(1'b1, 1'b0, OP_AND, 16'h0001, 16'h0001);
    tick();
    check("bp_release_valid", bus.rsp_valid, 32'd0);
    check("bp_release_busy", bus.busy, 32'd0);
    check("bp_no_grant1", bus.grant_count1, exp_cnt1);

    send(mk(1'b0, OP_SRL, 16'h8001, 16'h0000, 16'h4000, 1'b0, 1'b0, 1'b0), 1'b0);
    #1;
    reset = 1'b0;
    #1;
    check("rx_rsp_valid", bus.rsp_valid, 32'd0);
    check("rx_busy", bus.busy, 32'd0);
    check("rx_count0", bus.grant_count0, 32'd0);
    check("rx_count1", bus.grant_count1, 32'd0);
    tick();
    tick();
    check("rx_rsp_held_low", bus.rsp_valid, 32'd0);
    reset = 1'b1;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    run_both(1);
    wait_idle();
    check("rx_after_count0", bus.grant_count0, 32'd1);
    check("rx_after_count1", bus.grant_count1, 32'd1);

    for (int k = 1; exp_cnt0 < CMAX; k++)
      send(mk(1'b0, OP_OR, NB'(k), 16'h0000, NB'(k), 1'b0, 1'b0, 1'b0), 1'b1);
    wait_idle();
    check("count0_at_max", bus.grant_count0, CMAX);
    send(mk(1'b0, OP_OR, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1), 1'b1);
    wait_idle();
    check("count0_saturated", bus.grant_count0, CMAX);
    check("count1_untouched", bus.grant_count1, 32'd1);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
